// File: rtl/regfile_wb_sink.sv
// Register file fed by the writeback port: two combinational read ports with same-cycle bypass,
// plus a per-register in-flight counter that drives the decode stall; state updates on the next edge.
module regfile_wb_sink #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int CNT_W  = 2,
    localparam int IDX_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_in,
    input  logic [IDX_W-1:0]  writenum_in,
    input  logic [DATA_W-1:0] writeback_data_in,
    input  logic [IDX_W-1:0]  readnum_a,
    input  logic [IDX_W-1:0]  readnum_b,
    input  logic              check_a,
    input  logic              check_b,
    input  logic              issue_in,
    input  logic              issue_writes,
    input  logic [IDX_W-1:0]  issue_dst,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              stall_out,
    output logic [NREG-1:0]   busy_vec,
    output logic              err_sticky
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [CNT_W-1:0]  cnt_q  [NREG];
    logic [CNT_W-1:0]  cnt_d  [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    logic              err_q, err_d;

    logic              wr_en;
    logic              haz_a, haz_b;
    logic              inc;
    logic [NREG-1:0]   inc_v, dec_v;

    // Writes are blocked while reset is held so every output reads zero during reset.
    assign wr_en = write_in && !rst;

    always_comb begin
        rdata_a = (wr_en && writenum_in == readnum_a) ? writeback_data_in : regs_q[readnum_a];
        rdata_b = (wr_en && writenum_in == readnum_b) ? writeback_data_in : regs_q[readnum_b];

        // A lone pending write landing this cycle is covered by the bypass.
        haz_a = check_a && (cnt_q[readnum_a] != '0)
                && !(wr_en && writenum_in == readnum_a && cnt_q[readnum_a] == CNT_ONE);
        haz_b = check_b && (cnt_q[readnum_b] != '0)
                && !(wr_en && writenum_in == readnum_b && cnt_q[readnum_b] == CNT_ONE);

        stall_out = haz_a | haz_b;
        inc       = issue_in && issue_writes && !stall_out;
    end

    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int r = 0; r < NREG; r++) begin
            inc_v[r] = inc && (issue_dst == IDX_W'(r));
            dec_v[r] = wr_en && (writenum_in == IDX_W'(r));
        end
    end

    always_comb begin
        err_d  = err_q;
        busy_d = '0;
        for (int r = 0; r < NREG; r++) begin
            regs_d[r] = dec_v[r] ? writeback_data_in : regs_q[r];
            cnt_d[r]  = cnt_q[r];
            case ({inc_v[r], dec_v[r]})
                2'b10: begin
                    if (cnt_q[r] == CNT_MAX) err_d = 1'b1;
                    else                     cnt_d[r] = cnt_q[r] + CNT_ONE;
                end
                2'b01: begin
                    if (cnt_q[r] == '0) err_d = 1'b1;
                    else                cnt_d[r] = cnt_q[r] - CNT_ONE;
                end
                default: cnt_d[r] = cnt_q[r];
            endcase
            busy_d[r] = (cnt_d[r] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
            cnt_q  <= '{default: '0};
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign busy_vec   = busy_q;
    assign err_sticky = err_q;
endmodule
